// File: rtl/cfg_pkg.sv
// Shared definitions for the tile configuration loader: FSM encoding,
// header field positions and the config target indices.
package cfg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SKIP = 2'd2,
    DONE = 2'd3
  } cfg_state_e;

  localparam int ID_HI  = 31;
  localparam int ID_LO  = 24;
  localparam int CNT_HI = 7;
  localparam int CNT_LO = 0;
  localparam int ID_W   = ID_HI - ID_LO + 1;
  localparam int CNT_W  = CNT_HI - CNT_LO + 1;

  localparam int CFG_N   = 0;
  localparam int CFG_W   = 1;
  localparam int CFG_S   = 2;
  localparam int CFG_E   = 3;
  localparam int CFG_ALU = 4;

  function automatic logic [ID_W-1:0] hdr_id(input logic [31:0] word);
    return word[ID_HI:ID_LO];
  endfunction

  function automatic logic [CNT_W-1:0] hdr_cnt(input logic [31:0] word);
    return word[CNT_HI:CNT_LO];
  endfunction

endpackage

// File: rtl/cfg_onehot.sv
// Binary index to one-hot decoder; indices at or beyond NCFG decode to all zeros.
module cfg_onehot
  import cfg_pkg::*;
#(
  parameter int NCFG  = 5,
  parameter int IDX_W = CNT_W
) (
  input  logic [IDX_W-1:0] idx_i,
  output logic [NCFG-1:0]  onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NCFG; i++) begin
      if (idx_i == IDX_W'(i)) begin
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cfg_loader.sv
// Per-tile config loader: filters a header+payload stream by tile ID and
// turns matching payload words into one-hot write pulses for the config flops.
module cfg_loader
  import cfg_pkg::*;
#(
  parameter int         WIDTH   = 32,
  parameter int         NCFG    = 5,
  parameter logic [7:0] TILE_ID = 8'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [NCFG-1:0]  cfg_en,
  output logic [WIDTH-1:0] cfg_d,
  output logic             cfg_done,
  output logic             configured
);

  cfg_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] remain_q, remain_d;

  logic             accept;
  logic             load_beat;
  logic [CNT_W-1:0] hdr_n;
  logic [ID_W-1:0]  hdr_tile;
  logic [NCFG-1:0]  target_en;

  logic [NCFG-1:0]  cfg_en_q;
  logic [WIDTH-1:0] cfg_d_q;
  logic             cfg_done_q;
  logic             configured_q;

  assign hdr_n    = hdr_cnt(in_data[31:0]);
  assign hdr_tile = hdr_id(in_data[31:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      remain_q <= remain_d;
    end
  end

  // Zero-length headers are swallowed in IDLE regardless of the ID they carry.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    remain_d = remain_q;
    unique case (state_q)
      IDLE: begin
        if (accept && (hdr_n != '0)) begin
          remain_d = hdr_n;
          count_d  = '0;
          state_d  = (hdr_tile == TILE_ID) ? LOAD : SKIP;
        end
      end
      LOAD: begin
        if (accept) begin
          count_d  = count_q + CNT_W'(1);
          remain_d = remain_q - CNT_W'(1);
          if (remain_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      SKIP: begin
        if (accept) begin
          remain_d = remain_q - CNT_W'(1);
          if (remain_q == CNT_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = !reset && (state_q != DONE);
    accept    = in_valid && in_ready;
    load_beat = accept && (state_q == LOAD);
  end

  cfg_onehot #(
    .NCFG  (NCFG),
    .IDX_W (CNT_W)
  ) u_onehot (
    .idx_i    (count_q),
    .onehot_o (target_en)
  );

  // cfg_d is only refreshed on load beats so it holds between write pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_en_q     <= '0;
      cfg_d_q      <= '0;
      cfg_done_q   <= 1'b0;
      configured_q <= 1'b0;
    end else begin
      cfg_en_q   <= load_beat ? target_en : '0;
      cfg_done_q <= (state_q == DONE);
      if (load_beat) begin
        cfg_d_q <= in_data;
      end
      if (state_q == DONE) begin
        configured_q <= 1'b1;
      end
    end
  end

  assign cfg_en     = cfg_en_q;
  assign cfg_d      = cfg_d_q;
  assign cfg_done   = cfg_done_q;
  assign configured = configured_q;

endmodule

// File: tb/tb_cfg_loader.sv
// Self-checking bench for cfg_loader: a cycle-stamped scoreboard predicts every
// write pulse and done pulse, and each scenario task adds its own spot checks.
module tb_cfg_loader;
  import cfg_pkg::*;

  localparam int         WIDTH   = 32;
  localparam int         NCFG    = 5;
  localparam logic [7:0] TILE_ID = 8'd0;

  logic             clk      = 1'b0;
  logic             reset    = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data  = '0;
  logic [NCFG-1:0]  cfg_en;
  logic [WIDTH-1:0] cfg_d;
  logic             cfg_done;
  logic             configured;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int               cyc;
    logic [NCFG-1:0]  en;
    logic [WIDTH-1:0] d;
  } en_exp_t;

  en_exp_t    en_q[$];
  int         done_q[$];
  int         cyc     = 0;
  cfg_state_e m_state = IDLE;
  int         m_cnt   = 0;
  int         m_rem   = 0;
  logic       m_conf  = 1'b0;

  always #5 clk = ~clk;

  cfg_loader #(
    .WIDTH   (WIDTH),
    .NCFG    (NCFG),
    .TILE_ID (TILE_ID)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .cfg_en     (cfg_en),
    .cfg_d      (cfg_d),
    .cfg_done   (cfg_done),
    .configured (configured)
  );

  // Compares this cycle's outputs, then advances the reference model across the next edge.
  task automatic scoreboard_step();
    logic            rdy;
    logic            acc;
    en_exp_t         e;
    logic [NCFG-1:0] exp_en;
    rdy = !reset && (m_state != DONE);
    total++;
    if (in_ready !== rdy) begin
      bad++;
      $display("[TB] FAIL in_ready cyc=%0d got=%b want=%b", cyc, in_ready, rdy);
    end
    if (en_q.size() > 0 && en_q[0].cyc == cyc) begin
      e = en_q.pop_front();
      total++;
      if (cfg_en !== e.en || cfg_d !== e.d) begin
        bad++;
        $display("[TB] FAIL cfg_write cyc=%0d got en=%b d=%h want en=%b d=%h",
                 cyc, cfg_en, cfg_d, e.en, e.d);
      end
    end else begin
      total++;
      if (cfg_en !== '0) begin
        bad++;
        $display("[TB] FAIL cfg_en_idle cyc=%0d got=%b want=0", cyc, cfg_en);
      end
    end
    if (done_q.size() > 0 && done_q[0] == cyc) begin
      void'(done_q.pop_front());
      total++;
      if (cfg_done !== 1'b1) begin
        bad++;
        $display("[TB] FAIL cfg_done_pulse cyc=%0d got=%b want=1", cyc, cfg_done);
      end
    end else begin
      total++;
      if (cfg_done !== 1'b0) begin
        bad++;
        $display("[TB] FAIL cfg_done_idle cyc=%0d got=%b want=0", cyc, cfg_done);
      end
    end
    total++;
    if (configured !== m_conf) begin
      bad++;
      $display("[TB] FAIL configured cyc=%0d got=%b want=%b", cyc, configured, m_conf);
    end

    acc = in_valid && rdy;
    if (reset) begin
      m_state = IDLE;
      m_cnt   = 0;
      m_rem   = 0;
      m_conf  = 1'b0;
      en_q.delete();
      done_q.delete();
    end else begin
      case (m_state)
        IDLE: begin
          if (acc && in_data[7:0] != 8'd0) begin
            m_rem   = int'(in_data[7:0]);
            m_cnt   = 0;
            m_state = (in_data[31:24] == TILE_ID) ? LOAD : SKIP;
          end
        end
        LOAD: begin
          if (acc) begin
            if (m_cnt < NCFG) begin
              exp_en = NCFG'(1) << m_cnt;
              en_q.push_back('{cyc + 1, exp_en, in_data});
            end
            m_cnt++;
            m_rem--;
            if (m_rem == 0) begin
              m_state = DONE;
              done_q.push_back(cyc + 2);
            end
          end
        end
        SKIP: begin
          if (acc) begin
            m_rem--;
            if (m_rem == 0) m_state = IDLE;
          end
        end
        DONE: begin
          m_state = IDLE;
          m_conf  = 1'b1;
        end
        default: m_state = IDLE;
      endcase
    end
    cyc++;
  endtask

  always @(negedge clk) scoreboard_step();

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic sendWord(input logic [WIDTH-1:0] d);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("[TB] FAIL send_timeout word=%h got in_ready=%b want=1", d, in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    total++;
    if (en_q.size() != 0 || done_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s_drained got en_left=%0d done_left=%0d want 0/0",
               name, en_q.size(), done_q.size());
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total += 5;
    if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready got=%b want=0", in_ready); end
    if (cfg_en !== '0) begin bad++; $display("[TB] FAIL rst_en got=%b want=0", cfg_en); end
    if (cfg_d !== '0) begin bad++; $display("[TB] FAIL rst_d got=%h want=0", cfg_d); end
    if (cfg_done !== 1'b0) begin bad++; $display("[TB] FAIL rst_done got=%b want=0", cfg_done); end
    if (configured !== 1'b0) begin bad++; $display("[TB] FAIL rst_conf got=%b want=0", configured); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL post_rst_ready got=%b want=1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_local_packet();
    sendWord(32'h0000_0005);
    sendWord(32'd1);
    sendWord(32'd2);
    sendWord(32'd3);
    sendWord(32'd0);
    sendWord(32'd7);
    idle(4);
    total++;
    if (configured !== 1'b1) begin bad++; $display("[TB] FAIL local_conf got=%b want=1", configured); end
    check_drained("local");
  endtask

  task automatic test_foreign_skip();
    sendWord(32'h0500_0003);
    sendWord(32'd9);
    sendWord(32'd9);
    sendWord(32'd9);
    in_valid = 1'b1;
    in_data  = 32'h0000_0001;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL skip_next_hdr got=%b want=1", in_ready); end
    @(posedge clk);
    #1;
    sendWord(32'h0000_0055);
    idle(4);
    check_drained("skip");
  endtask

  task automatic test_overflow();
    sendWord(32'h0000_0007);
    for (int i = 1; i <= 7; i++) sendWord(WIDTH'(i));
    idle(4);
    check_drained("overflow");
  endtask

  task automatic test_valid_toggle();
    applyStimulus(1'b1, 32'h0000_0002);
    applyStimulus(1'b0, 32'h0000_BAD0);
    applyStimulus(1'b0, 32'h0000_BAD1);
    applyStimulus(1'b1, 32'h0000_0021);
    applyStimulus(1'b1, 32'h0000_0022);
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL done_ready got=%b want=0", in_ready); end
    @(posedge clk);
    #1;
    idle(3);
    check_drained("toggle");
  endtask

  task automatic test_zero_count();
    sendWord(32'h0000_0000);
    sendWord(32'h0700_0000);
    sendWord(32'h0000_0001);
    sendWord(32'h0000_000A);
    idle(4);
    check_drained("zero");
  endtask

  task automatic test_back_to_back();
    sendWord(32'h0000_0002);
    sendWord(32'h0000_00A1);
    sendWord(32'h0000_00A2);
    in_valid = 1'b1;
    in_data  = 32'h0000_0001;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL b2b_done_ready got=%b want=0", in_ready); end
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_hdr_ready got=%b want=1", in_ready); end
    @(posedge clk);
    #1;
    sendWord(32'h0000_00B1);
    idle(4);
    check_drained("b2b");
  endtask

  task automatic test_reset_mid_packet();
    sendWord(32'h0000_0005);
    sendWord(32'h0000_0011);
    sendWord(32'h0000_0022);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    total += 2;
    if (configured !== 1'b0) begin bad++; $display("[TB] FAIL midrst_conf got=%b want=0", configured); end
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL midrst_ready got=%b want=1", in_ready); end
    @(posedge clk);
    #1;
    sendWord(32'h0000_0001);
    sendWord(32'h0000_0077);
    idle(4);
    check_drained("midrst");
  endtask

  task automatic test_long_packet();
    sendWord(32'h0000_00FF);
    for (int i = 0; i < 255; i++) sendWord(32'h100 + WIDTH'(i));
    idle(4);
    total++;
    if (configured !== 1'b1) begin bad++; $display("[TB] FAIL long_conf got=%b want=1", configured); end
    check_drained("long");
  endtask

  initial begin
    $display("[TB] cfg_loader bench start");
    test_reset();
    test_local_packet();
    test_foreign_skip();
    test_overflow();
    test_valid_toggle();
    test_zero_count();
    test_back_to_back();
    test_reset_mid_packet();
    test_long_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
